// File: rtl/utils_pkg.sv
// Shared AXI4 bus types and constants for the system interconnect, plus the
// state encoding used by the simple-bus AXI initiator.
package utils_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_USER_W = 1;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'd1;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_error_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AW_W,
    WR_B,
    RSP
  } sbus_fsm_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic [3:0]            awregion;
    logic [AXI_USER_W-1:0] awuser;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic [AXI_USER_W-1:0] wuser;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;
    logic [AXI_USER_W-1:0] aruser;
    logic                  arvalid;
    logic                  rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    axi_error_t            bresp;
    logic [AXI_USER_W-1:0] buser;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    axi_error_t            rresp;
    logic                  rlast;
    logic [AXI_USER_W-1:0] ruser;
    logic                  rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/axi_sbus_master.sv
// Single-outstanding AXI4 initiator: converts a valid/ready word request into
// one single-beat AXI read or write and returns data/error on a response port.
module axi_sbus_master
  import utils_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] AXI_ID      = '0,
  parameter int unsigned         TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output s_axi_mosi_t axi_mosi,
  input  s_axi_miso_t axi_miso
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  sbus_fsm_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic [31:0]      addr_q, wdata_q, rdata_q, rdata_next;
  logic [3:0]       wstrb_q;
  logic             err_q, err_next;
  logic             aw_done, aw_done_next, w_done, w_done_next;
  logic             arvalid_q, awvalid_q, wvalid_q, rready_q, bready_q;
  logic             accept, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic             counting, timeout;
  logic             unused_miso;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign ar_hs     = arvalid_q && axi_miso.arready;
  assign r_hs      = rready_q && axi_miso.rvalid;
  assign aw_hs     = awvalid_q && axi_miso.awready;
  assign w_hs      = wvalid_q && axi_miso.wready;
  assign b_hs      = bready_q && axi_miso.bvalid;

  assign counting = (state == RD_AR) || (state == RD_R) ||
                    (state == WR_AW_W) || (state == WR_B);
  assign cnt_inc  = cnt + CNT_W'(1);
  // A zero limit disables the abort; the counter may wrap harmlessly then.
  assign timeout  = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_LIMIT);

  assign unused_miso = ^{axi_miso.bid, axi_miso.buser, axi_miso.rid, axi_miso.ruser};

  always_comb begin
    state_next   = state;
    rdata_next   = rdata_q;
    err_next     = err_q;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    unique case (state)
      IDLE: begin
        if (accept) begin
          rdata_next   = '0;
          err_next     = 1'b0;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = req_we ? WR_AW_W : RD_AR;
        end
      end
      RD_AR: begin
        if (ar_hs) begin
          state_next = RD_R;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = RSP;
        end
      end
      RD_R: begin
        if (r_hs) begin
          rdata_next = axi_miso.rdata;
          err_next   = (axi_miso.rresp != AXI_OKAY) || !axi_miso.rlast;
          state_next = RSP;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = RSP;
        end
      end
      WR_AW_W: begin
        aw_done_next = aw_done || aw_hs;
        w_done_next  = w_done || w_hs;
        if (aw_done_next && w_done_next) begin
          state_next = WR_B;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = RSP;
        end
      end
      WR_B: begin
        if (b_hs) begin
          err_next   = (axi_miso.bresp != AXI_OKAY);
          state_next = RSP;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    cnt_next = (counting && (state_next == state)) ? cnt_inc : '0;
  end

  // AXI valids/readies are registered from the next state so no bus input
  // reaches a bus output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      rdata_q <= rdata_next;
      err_q   <= err_next;
      aw_done <= aw_done_next;
      w_done  <= w_done_next;
      if (accept) begin
        addr_q  <= {req_addr[31:2], 2'b00};
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      arvalid_q <= (state_next == RD_AR);
      awvalid_q <= (state_next == WR_AW_W) && !aw_done_next;
      wvalid_q  <= (state_next == WR_AW_W) && !w_done_next;
      rready_q  <= (state_next == RD_R);
      bready_q  <= (state_next == WR_B);
    end
  end

  assign rsp_valid = (state == RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    axi_mosi          = '0;
    axi_mosi.awid     = AXI_ID;
    axi_mosi.awaddr   = addr_q;
    axi_mosi.awlen    = 8'd0;
    axi_mosi.awsize   = AXI_SIZE_WORD;
    axi_mosi.awburst  = AXI_BURST_INCR;
    axi_mosi.awvalid  = awvalid_q;
    axi_mosi.wdata    = wdata_q;
    axi_mosi.wstrb    = wstrb_q;
    axi_mosi.wlast    = 1'b1;
    axi_mosi.wvalid   = wvalid_q;
    axi_mosi.bready   = bready_q;
    axi_mosi.arid     = AXI_ID;
    axi_mosi.araddr   = addr_q;
    axi_mosi.arlen    = 8'd0;
    axi_mosi.arsize   = AXI_SIZE_WORD;
    axi_mosi.arburst  = AXI_BURST_INCR;
    axi_mosi.arvalid  = arvalid_q;
    axi_mosi.rready   = rready_q;
  end

endmodule

// File: tb/tb_axi_sbus_master.sv
// Directed bench for axi_sbus_master: a reactive single-beat AXI slave model
// driven on the falling edge, with hand-computed expected responses.
module tb_axi_sbus_master;
  import utils_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;

  int vectors = 0;
  int miscompares = 0;

  int          arDelay, awDelay, wDelay, arWait, awWait, wWait;
  bit          arNever, bNever;
  logic [31:0] slvRdata;
  logic        slvRlast;
  axi_error_t  slvRresp, slvBresp;
  bit          arHsPending, rHsPending, awHsPending, wHsPending, bHsPending;
  bit          awSeen, wSeen, bIssued, sawAwOnly;
  logic [31:0] capAraddr, capAwaddr, capWdata;
  logic [7:0]  capArlen;
  logic [2:0]  capArsize;
  logic [3:0]  capWstrb;
  logic        capWlast;

  axi_sbus_master #(.AXI_ID(4'd0), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .axi_mosi(axi_mosi), .axi_miso(axi_miso)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic resetSlave();
    axi_miso = '0;
    arDelay = 0; awDelay = 0; wDelay = 0;
    arWait = 0; awWait = 0; wWait = 0;
    arNever = 0; bNever = 0;
    slvRdata = '0; slvRlast = 1'b1;
    slvRresp = AXI_OKAY; slvBresp = AXI_OKAY;
    arHsPending = 0; rHsPending = 0; awHsPending = 0; wHsPending = 0; bHsPending = 0;
    awSeen = 0; wSeen = 0; bIssued = 0; sawAwOnly = 0;
  endtask

  // Called each falling edge: DUT outputs are stable until the next rising
  // edge, so any handshake decided here happens on that edge.
  task automatic slaveStep();
    if (rHsPending)  begin axi_miso.rvalid = 1'b0; rHsPending = 0; end
    if (bHsPending)  begin axi_miso.bvalid = 1'b0; bHsPending = 0; end
    if (awHsPending) begin axi_miso.awready = 1'b0; awHsPending = 0; awSeen = 1; end
    if (wHsPending)  begin axi_miso.wready = 1'b0; wHsPending = 0; wSeen = 1; end
    if (arHsPending) begin
      axi_miso.arready = 1'b0;
      arHsPending = 0;
      axi_miso.rvalid = 1'b1;
      axi_miso.rdata = slvRdata;
      axi_miso.rresp = slvRresp;
      axi_miso.rlast = slvRlast;
    end
    if (awSeen && wSeen && !bIssued && !bNever) begin
      axi_miso.bvalid = 1'b1;
      axi_miso.bresp = slvBresp;
      bIssued = 1;
    end
    if (axi_mosi.awvalid && !axi_mosi.wvalid) sawAwOnly = 1;
    if (axi_mosi.arvalid && !axi_miso.arready && !arNever) begin
      if (arWait >= arDelay) axi_miso.arready = 1'b1;
      else arWait++;
    end
    if (axi_mosi.awvalid && !axi_miso.awready) begin
      if (awWait >= awDelay) axi_miso.awready = 1'b1;
      else awWait++;
    end
    if (axi_mosi.wvalid && !axi_miso.wready) begin
      if (wWait >= wDelay) axi_miso.wready = 1'b1;
      else wWait++;
    end
    if (axi_mosi.arvalid && axi_miso.arready) begin
      arHsPending = 1;
      capAraddr = axi_mosi.araddr; capArlen = axi_mosi.arlen; capArsize = axi_mosi.arsize;
    end
    if (axi_mosi.awvalid && axi_miso.awready) begin
      awHsPending = 1;
      capAwaddr = axi_mosi.awaddr;
    end
    if (axi_mosi.wvalid && axi_miso.wready) begin
      wHsPending = 1;
      capWdata = axi_mosi.wdata; capWstrb = axi_mosi.wstrb; capWlast = axi_mosi.wlast;
    end
    if (axi_miso.rvalid && axi_mosi.rready) rHsPending = 1;
    if (axi_miso.bvalid && axi_mosi.bready) bHsPending = 1;
  endtask

  task automatic cycle();
    @(negedge clk);
    slaveStep();
  endtask

  // Issues one request from a falling edge in IDLE and waits (bounded) for
  // rsp_valid; lat counts cycles from the accept cycle to the response cycle.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input int maxCyc, output int lat,
                               output logic [31:0] rdata, output logic err);
    req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < maxCyc) begin
      cycle();
      lat++;
    end
    checkOutput("rsp_arrived", rsp_valid, 1);
    rdata = rsp_rdata;
    err = rsp_err;
  endtask

  task automatic finishTxn(input string tag);
    cycle();
    checkOutput(tag, {rsp_valid, req_ready}, 2'b01);
  endtask

  int          lat;
  logic [31:0] rdata;
  logic        err;
  bit          stableBad;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
    resetSlave();
    repeat (3) cycle();
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
    checkOutput("rst_axi_hs", {axi_mosi.arvalid, axi_mosi.awvalid, axi_mosi.wvalid,
                               axi_mosi.rready, axi_mosi.bready}, 5'b0);
    rst = 1'b0;
    cycle();
    checkOutput("post_rst_req_ready", req_ready, 1);

    $display("[TB] basic read");
    resetSlave(); slvRdata = 32'hDEADBEEF;
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0, 40, lat, rdata, err);
    checkOutput("rd_latency", lat, 3);
    checkOutput("rd_rdata", rdata, 32'hDEADBEEF);
    checkOutput("rd_err", err, 0);
    checkOutput("rd_araddr", capAraddr, 32'h10);
    checkOutput("rd_arlen_size", {capArlen, capArsize}, {8'd0, 3'd2});
    finishTxn("rd_done");

    $display("[TB] write with late awready");
    resetSlave(); awDelay = 4;
    applyStimulus(1'b1, 32'h0000_0104, 32'h1234_5678, 4'h3, 40, lat, rdata, err);
    checkOutput("wr_latency", lat, 7);
    checkOutput("wr_aw_only_seen", sawAwOnly, 1);
    checkOutput("wr_awaddr", capAwaddr, 32'h104);
    checkOutput("wr_wdata", capWdata, 32'h1234_5678);
    checkOutput("wr_wstrb_wlast", {capWstrb, capWlast}, 5'b0011_1);
    checkOutput("wr_rsp", {err, rdata}, 33'h0);
    finishTxn("wr_done");

    $display("[TB] minimum-latency write");
    resetSlave();
    applyStimulus(1'b1, 32'h0000_0008, 32'hCAFE_0001, 4'hF, 40, lat, rdata, err);
    checkOutput("wr_min_latency", lat, 3);
    checkOutput("wr_min_err", err, 0);
    finishTxn("wr_min_done");

    $display("[TB] error responses");
    resetSlave(); slvRdata = 32'h1111_2222; slvRresp = AXI_SLVERR;
    applyStimulus(1'b0, 32'h0000_0023, 32'h0, 4'h0, 40, lat, rdata, err);
    checkOutput("slverr_err", err, 1);
    checkOutput("slverr_araddr", capAraddr, 32'h20);
    finishTxn("slverr_done");
    resetSlave(); slvBresp = AXI_DECERR;
    applyStimulus(1'b1, 32'h0000_0030, 32'h0BAD_0BAD, 4'hF, 40, lat, rdata, err);
    checkOutput("decerr_err", err, 1);
    finishTxn("decerr_done");
    resetSlave(); slvRdata = 32'h5555_AAAA;
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0, 40, lat, rdata, err);
    checkOutput("recover_rsp", {err, rdata}, {1'b0, 32'h5555_AAAA});
    finishTxn("recover_done");

    $display("[TB] missing rlast");
    resetSlave(); slvRdata = 32'hCAFE_F00D; slvRlast = 1'b0;
    applyStimulus(1'b0, 32'h0000_0044, 32'h0, 4'h0, 40, lat, rdata, err);
    checkOutput("norlast_rsp", {err, rdata}, {1'b1, 32'hCAFE_F00D});
    finishTxn("norlast_done");

    $display("[TB] arready timeout");
    resetSlave(); arNever = 1;
    applyStimulus(1'b0, 32'h0000_0080, 32'h0, 4'h0, 40, lat, rdata, err);
    checkOutput("tmo_cycles", lat - 1, 16);
    checkOutput("tmo_rsp", {err, rdata}, {1'b1, 32'h0});
    checkOutput("tmo_arvalid", axi_mosi.arvalid, 0);
    finishTxn("tmo_done");
    checkOutput("tmo_arvalid_after", axi_mosi.arvalid, 0);

    $display("[TB] response back-pressure");
    resetSlave(); rsp_ready = 1'b0;
    applyStimulus(1'b1, 32'h0000_0200, 32'hA5A5_0F0F, 4'hF, 40, lat, rdata, err);
    stableBad = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b0)
        stableBad = 1;
    end
    checkOutput("stall_stable", stableBad, 0);
    rsp_ready = 1'b1;
    finishTxn("stall_done");

    $display("[TB] reset during WR_B");
    resetSlave(); bNever = 1;
    req_we = 1'b1; req_addr = 32'h0000_0300; req_wdata = 32'h7777_8888;
    req_wstrb = 4'hF; req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    for (int i = 0; i < 8 && axi_mosi.bready !== 1'b1; i++) cycle();
    checkOutput("wrb_reached", axi_mosi.bready, 1);
    rst = 1'b1;
    cycle();
    checkOutput("midrst_axi_hs", {axi_mosi.arvalid, axi_mosi.awvalid, axi_mosi.wvalid,
                                  axi_mosi.rready, axi_mosi.bready}, 5'b0);
    checkOutput("midrst_rsp", {rsp_valid, rsp_err, rsp_rdata, req_ready}, 35'h0);
    resetSlave();
    rst = 1'b0;
    cycle();
    checkOutput("midrst_req_ready", req_ready, 1);
    slvRdata = 32'h0BAD_CAFE;
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'h0, 40, lat, rdata, err);
    checkOutput("fresh_latency", lat, 3);
    checkOutput("fresh_rsp", {err, rdata}, {1'b0, 32'h0BAD_CAFE});
    finishTxn("fresh_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_sbus_master.md
# axi_sbus_master

Single-outstanding AXI4 initiator that turns a simple valid/ready word-request port into single-beat AXI4 read or write transactions. It is the master-side counterpart of the slave wrappers on the system interconnect (boot ROM, RAM, peripherals). It lets a non-AXI block such as a debug bridge, DMA stub or test sequencer access any slave on the crossbar. It carries `utils_pkg` AXI struct types on the bus side.

## Interface
- `AXI_ID` — default `0` — constant ID driven on `awid` and `arid`.
- `TIMEOUT_CYC` — default `1024` — cycles to wait for any AXI handshake before aborting with error; `0` disables the timeout.
- `clk` — in — 1 — system clock.
- `rst` — in — 1 — synchronous, active-high reset. One clock, `clk`, drives the whole block; reset is sampled only on the rising edge of `clk`.
- `req_valid` — in — 1 — request present.
- `req_ready` — out — 1 — request accepted this cycle when high together with `req_valid`.
- `req_we` — in — 1 — 1 = write, 0 = read.
- `req_addr` — in — 32 — byte address; bits [1:0] are forced to 0 on the bus.
- `req_wdata` — in — 32 — write data.
- `req_wstrb` — in — 4 — write byte strobes.
- `rsp_valid` — out — 1 — response present.
- `rsp_ready` — in — 1 — response consumed.
- `rsp_rdata` — out — 32 — read data; 0 for writes.
- `rsp_err` — out — 1 — any of: non-OKAY resp, missing `rlast`, timeout.
- `axi_mosi` — out — `s_axi_mosi_t` — AXI master-to-slave channels.
- `axi_miso` — in — `s_axi_miso_t` — AXI slave-to-master channels.

## Operation
- FSM states: `IDLE`, `RD_AR`, `RD_R`, `WR_AW_W`, `WR_B`, `RSP`.
- `IDLE`: `req_ready=1`. On accept, register addr/wdata/wstrb/we and go to `RD_AR` if `we=0`, else `WR_AW_W`.
- `RD_AR`: `arvalid=1` with fixed `araddr`. On `arready`, go to `RD_R`.
- `RD_R`: `rready=1`. On `rvalid`, capture `rdata`; set err if `rresp!=OKAY` or `rlast=0`; go to `RSP`.
- `WR_AW_W`: `awvalid` and `wvalid` asserted together, with `wlast=1`. Each valid drops independently after its own handshake, tracked by `aw_done`/`w_done` flags. When both are done (same cycle allowed), go to `WR_B`.
- `WR_B`: `bready=1`. On `bvalid`, set err if `bresp!=OKAY`; go to `RSP`.
- `RSP`: `rsp_valid=1`; `rsp_*` stable until `rsp_ready`, then return to `IDLE`.
- Fixed attributes on every transaction: `len=0`, `size=2` (4 bytes), `burst=INCR`, `lock/cache/prot/qos/region/user=0`.
- Timeout: a counter clears on every state entry and counts in `RD_AR`, `RD_R`, `WR_AW_W` and `WR_B`. Reaching `TIMEOUT_CYC` goes to `RSP` with `rsp_err=1` and `rdata=0`, and drops all AXI valids. A late response from the slave in `IDLE` is absorbed: `rready`/`bready` are held 0, so it stalls the slave; this is the documented system-fault behaviour.
- Only one transaction is outstanding. No new request is accepted until the response is consumed.

## Timing
- Reset values: `req_ready=0` during reset and 1 from the first cycle after reset; `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`; all AXI valids and readies 0; FSM in `IDLE`; counter 0.
- Accept at edge N: `arvalid`/`awvalid`/`wvalid` are high from cycle N+1. All AXI outputs are registered, with no combinational path from `axi_miso` to `axi_mosi`.
- Minimum read latency, with a slave that has `arready=1` and single-cycle `rvalid`: accept→`rsp_valid` is 3 cycles.
- Minimum write latency, with AW/W/B each handshaking immediately: 3 cycles.
- Valid signals never deassert before their handshake, and addr/data stay stable while valid, per AXI.
- `rsp_valid` with `rsp_ready` already high completes in the same cycle; `req_ready` is back high the next cycle.
- `rst` asserted mid-transaction: all outputs return to reset values on the next edge and any pending response is discarded.

## Structure
- Add to `utils_pkg`: `sbus_fsm_t` (state enum), plus constants `AXI_SIZE_WORD` (2) and `AXI_BURST_INCR` (1). Reuse the existing `axi_error_t` for resp decoding.
- Single module; no sub-module needed. The timeout counter is inline, with width `$clog2(TIMEOUT_CYC+1)`.

## Test plan
- Read 0x0000_0010 from a slave model returning 0xDEADBEEF, OKAY, `rlast=1` → `araddr=0x10`, `arlen=0`, `arsize=2`; `rsp_rdata=0xDEADBEEF`, `rsp_err=0`, 3-cycle latency.
- Write 0x1234_5678, wstrb 0x3, to 0x0000_0104 with `awready` 4 cycles after `wready` → `awvalid`/`wvalid` drop independently; `wlast=1`, `wstrb=0x3`; `rsp_err=0`.
- Read with `rresp=SLVERR`, then a write with `bresp=DECERR` → `rsp_err=1` for both; next request proceeds normally.
- Read where `rvalid` arrives with `rlast=0` → `rsp_err=1`, `rsp_rdata` equals the captured data.
- Slave never asserts `arready`, with `TIMEOUT_CYC=16` → `rsp_valid` with `rsp_err=1` exactly 16 cycles after entering `RD_AR`; `arvalid` low afterwards.
- `rsp_ready` held 0 for 10 cycles, then reset asserted mid-`WR_B` → `rsp` held stable with `req_ready=0` throughout; after reset, all outputs are at reset values and a fresh read completes.
